// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: instruction-memory req/ack side plus the decode valid/ready side.
interface instr_fetch_if #(
  parameter int unsigned ADDR_W = 64
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic [31:0]       instr;
  logic              instr_valid;
  logic              instr_ready;
  logic [1:0]        brTaken;
  logic              uncondBr;
  logic [ADDR_W-1:0] br_reg;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic              fault;

  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, fault,
    input  imem_ack, imem_rdata, instr_ready, brTaken, uncondBr, br_reg
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, fault,
    output imem_ack, imem_rdata, instr_ready, brTaken, uncondBr, br_reg
  );
endinterface

// File: rtl/instr_fetch.sv
// Sequential instruction-fetch unit: PC, memory req/ack, decode valid/ready, next-PC select.
// IFETCH_ALIGN_CHECK_EN enables the sticky misaligned-target FAULT state.
module instr_fetch #(
  parameter int unsigned       ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FAULT} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] pc_load;
  logic [ADDR_W-1:0] off26;
  logic [ADDR_W-1:0] off19;
  logic [31:0]       instr_q;
  logic              valid_q;
  logic              accept;
  logic              misaligned;

  assign accept = (state == HOLD) && valid_q && bus.instr_ready;

  // Branch offsets are word counts: sign-extend, then scale by 4.
  assign off26 = {{(ADDR_W-28){instr_q[25]}}, instr_q[25:0], 2'b00};
  assign off19 = {{(ADDR_W-21){instr_q[23]}}, instr_q[23:5], 2'b00};

  always_comb begin
    next_pc = pc_q + ADDR_W'(4);
    case (bus.brTaken)
      2'b01:   next_pc = pc_q + (bus.uncondBr ? off26 : off19);
      2'b10:   next_pc = bus.br_reg;
      default: next_pc = pc_q + ADDR_W'(4);
    endcase
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  assign misaligned = (next_pc[1:0] != 2'b00);
  assign pc_load    = next_pc;
`else
  assign misaligned = 1'b0;
  assign pc_load    = next_pc & ~ADDR_W'(3);
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = FETCH;
      FETCH:   if (bus.imem_ack) state_next = HOLD;
      HOLD:    if (accept) state_next = misaligned ? FAULT : FETCH;
      FAULT:   state_next = FAULT;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.imem_req = (state == FETCH);
`ifdef IFETCH_ALIGN_CHECK_EN
    bus.fault    = (state == FAULT);
`else
    bus.fault    = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else if ((state == FETCH) && bus.imem_ack) begin
      instr_q <= bus.imem_rdata;
      valid_q <= 1'b1;
    end else if (accept) begin
      pc_q    <= pc_load;
      valid_q <= 1'b0;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_q + ADDR_W'(4);
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed plus randomized bench for instr_fetch; acts as instruction memory and decode.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  logic [63:0] mpc;
  logic [31:0] minstr;
  logic        mfault;

  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_W(64)) bus ();

  instr_fetch #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Branch target from the architectural rules, using signed integer arithmetic.
  function automatic logic [63:0] model_next(input logic [63:0] p, input logic [31:0] ins,
                                             input logic [1:0] bt, input logic unc,
                                             input logic [63:0] r);
    longint off;
    if (bt == 2'd1) begin
      if (unc) off = longint'($signed(ins[25:0]));
      else     off = longint'($signed(ins[23:5]));
      return p + 64'(off * 4);
    end
    if (bt == 2'd2) return r;
    return p + 64'd4;
  endfunction

  task automatic do_fetch(input logic [31:0] word, input int dly);
    for (int i = 0; i < dly; i++) begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = $urandom;
      chk("wait_req", 64'(bus.imem_req), 64'd1);
      chk("wait_addr", bus.imem_addr, mpc);
      chk("wait_valid", 64'(bus.instr_valid), 64'd0);
      step();
    end
    chk("req", 64'(bus.imem_req), 64'd1);
    chk("addr", bus.imem_addr, mpc);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    step();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = $urandom;
    minstr = word;
    chk("valid", 64'(bus.instr_valid), 64'd1);
    chk("instr", 64'(bus.instr), 64'(word));
    chk("req_low", 64'(bus.imem_req), 64'd0);
    chk("pc_plus4", bus.pc_plus4, mpc + 64'd4);
  endtask

  task automatic do_accept(input logic [1:0] bt, input logic unc, input logic [63:0] breg,
                           input int dly);
    logic [63:0] nxt;
    for (int i = 0; i < dly; i++) begin
      bus.instr_ready = 1'b0;
      bus.brTaken     = 2'($urandom);
      bus.br_reg      = {$urandom, $urandom};
      bus.imem_ack    = 1'($urandom);
      step();
      chk("hold_valid", 64'(bus.instr_valid), 64'd1);
      chk("hold_instr", 64'(bus.instr), 64'(minstr));
      chk("hold_req", 64'(bus.imem_req), 64'd0);
      chk("hold_pc", bus.pc, mpc);
    end
    bus.imem_ack    = 1'b0;
    bus.instr_ready = 1'b1;
    bus.brTaken     = bt;
    bus.uncondBr    = unc;
    bus.br_reg      = breg;
    nxt = model_next(mpc, minstr, bt, unc, breg);
    step();
    bus.instr_ready = 1'b0;
    bus.brTaken     = 2'($urandom);
    bus.br_reg      = {$urandom, $urandom};
`ifdef IFETCH_ALIGN_CHECK_EN
    mfault = (nxt[1:0] != 2'b00);
    mpc    = nxt;
`else
    mfault = 1'b0;
    mpc    = {nxt[63:2], 2'b00};
`endif
    chk("acc_valid", 64'(bus.instr_valid), 64'd0);
    chk("acc_pc", bus.pc, mpc);
    chk("acc_req", 64'(bus.imem_req), 64'(!mfault));
    chk("acc_fault", 64'(bus.fault), 64'(mfault));
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    bus.imem_ack    = 1'b0;
    bus.instr_ready = 1'b0;
    step();
    step();
    chk("rst_req", 64'(bus.imem_req), 64'd0);
    chk("rst_addr", bus.imem_addr, 64'd0);
    chk("rst_instr", 64'(bus.instr), 64'd0);
    chk("rst_valid", 64'(bus.instr_valid), 64'd0);
    chk("rst_pc", bus.pc, 64'd0);
    chk("rst_pc_plus4", bus.pc_plus4, 64'd4);
    chk("rst_fault", 64'(bus.fault), 64'd0);
    reset          = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = $urandom;
    step();
    bus.imem_ack = 1'b0;
    chk("idle_ack_ignored", 64'(bus.instr_valid), 64'd0);
    mpc    = 64'd0;
    minstr = 32'd0;
    mfault = 1'b0;
  endtask

  initial begin
    logic [63:0] breg;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = '0;
    bus.instr_ready = 1'b0;
    bus.brTaken     = 2'b00;
    bus.uncondBr    = 1'b0;
    bus.br_reg      = '0;
    do_reset();

    do_fetch(32'h8B02_0020, 0);
    do_accept(2'b00, 1'b0, 64'h0, 4);
    chk("bp_next_addr", bus.imem_addr, 64'h4);
    do_fetch($urandom, 5);

    do_accept(2'b10, 1'b0, 64'h100, 0);
    do_fetch(32'h17FF_FFFC, 1);
    do_accept(2'b01, 1'b1, 64'h0, 0);
    chk("b_target", bus.imem_addr, 64'hF0);

    do_fetch($urandom, 0);
    do_accept(2'b10, 1'b0, 64'h100, 0);
    do_fetch(32'hB400_0060, 0);
    do_accept(2'b01, 1'b0, 64'h0, 0);
    chk("cbz_target", bus.imem_addr, 64'h10C);

    do_fetch($urandom, 0);
    do_accept(2'b10, 1'b0, 64'h2000, 0);
    chk("br_target", bus.imem_addr, 64'h2000);

    do_fetch($urandom, 0);
    do_accept(2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    do_fetch($urandom, 0);
    do_accept(2'b00, 1'b0, 64'h0, 0);
    chk("wrap_target", bus.imem_addr, 64'h0);

    do_fetch($urandom, 0);
    do_accept(2'b11, 1'b1, 64'h5550, 0);
    chk("reserved_sel", bus.imem_addr, 64'h4);

    // Reset coincident with ack while a request is outstanding.
    reset          = 1'b1;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = $urandom;
    step();
    reset        = 1'b0;
    bus.imem_ack = 1'b0;
    chk("midrst_valid", 64'(bus.instr_valid), 64'd0);
    chk("midrst_req", 64'(bus.imem_req), 64'd0);
    chk("midrst_instr", 64'(bus.instr), 64'd0);
    chk("midrst_pc", bus.pc, 64'd0);
    step();
    chk("restart_req", 64'(bus.imem_req), 64'd1);
    chk("restart_addr", bus.imem_addr, 64'd0);
    mpc    = 64'd0;
    minstr = 32'd0;

    do_fetch($urandom, 0);
    do_accept(2'b10, 1'b0, 64'h2002, 0);
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("align_fault", 64'(bus.fault), 64'd1);
    chk("align_pc", bus.pc, 64'h2002);
    for (int i = 0; i < 3; i++) begin
      bus.imem_ack    = 1'b1;
      bus.instr_ready = 1'b1;
      step();
      chk("fault_no_req", 64'(bus.imem_req), 64'd0);
      chk("fault_sticky", 64'(bus.fault), 64'd1);
      chk("fault_no_valid", 64'(bus.instr_valid), 64'd0);
    end
`else
    chk("align_masked", bus.imem_addr, 64'h2000);
    chk("align_nofault", 64'(bus.fault), 64'd0);
`endif
    do_reset();

    for (int n = 0; n < 150; n++) begin
      do_fetch($urandom, int'($urandom_range(0, 3)));
      breg = {$urandom, $urandom};
`ifdef IFETCH_ALIGN_CHECK_EN
      breg[1:0] = 2'b00;
`endif
      do_accept(2'($urandom), 1'($urandom), breg, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
